// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory responder: I/O addresses, status bits
// and the bus address decoder.
package cpu_mem_pkg;

  localparam logic [17:0] IO_TX_ADDR     = 18'h30000;
  localparam logic [17:0] IO_STATUS_ADDR = 18'h30004;
  localparam int          IO_SEL_BIT     = 17;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_TX,
    SEL_STATUS,
    SEL_NONE
  } bus_sel_e;

  // Unlisted I/O addresses fall into SEL_NONE: writes dropped, reads give zero.
  function automatic bus_sel_e decode_addr(input logic [17:0] addr);
    if (!addr[IO_SEL_BIT])
      return SEL_RAM;
    else if (addr == IO_TX_ADDR)
      return SEL_TX;
    else if (addr == IO_STATUS_ADDR)
      return SEL_STATUS;
    else
      return SEL_NONE;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with asynchronous reset; the head byte is presented
// directly from storage so it is visible the cycle after it was pushed.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = storage[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_in) begin
    if (do_push)
      storage[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Responder side of the CPU byte bus: internal RAM, TX console FIFO, status
// port and sticky halt flag, with one-cycle registered read data.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        rdy_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        sim_halt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]            ram [2**RAM_ADDR_W];
  logic [RAM_ADDR_W-1:0] ram_idx;
  bus_sel_e              sel;
  logic                  tx_write;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [7:0]            status_byte;
  logic [7:0]            read_byte;
  logic                  unused_ok;

  assign sel       = decode_addr(cpu_a[17:0]);
  assign ram_idx   = cpu_a[RAM_ADDR_W-1:0];
  assign tx_write  = cpu_wr && (sel == SEL_TX);
  assign rdy_out   = !(tx_write && fifo_full);
  assign fifo_push = tx_write && !fifo_full;
  assign fifo_pop  = tx_valid && tx_ready;
  assign tx_valid  = !fifo_empty;
  assign unused_ok = ^{cpu_a[31:18], fifo_count};

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (fifo_push),
    .push_data (cpu_dout),
    .pop       (fifo_pop),
    .head_data (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    status_byte             = 8'h00;
    status_byte[STAT_FULL]  = fifo_full;
    status_byte[STAT_EMPTY] = fifo_empty;
  end

  always_comb begin
    read_byte = 8'h00;
    case (sel)
      SEL_RAM:    read_byte = ram[ram_idx];
      SEL_STATUS: read_byte = status_byte;
      default:    read_byte = 8'h00;
    endcase
  end

  // RAM contents survive reset, so the array has its own unreset process.
  always_ff @(posedge clk_in) begin
    if (cpu_wr && (sel == SEL_RAM))
      ram[ram_idx] <= cpu_dout;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      cpu_din <= 8'h00;
    else if (!cpu_wr && rdy_out)
      cpu_din <= read_byte;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      sim_halt <= 1'b0;
    else if (cpu_wr && (sel == SEL_STATUS))
      sim_halt <= 1'b1;
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed self-checking bench for cpu_mem_responder with hand-computed
// expected values for RAM, TX FIFO, stall, halt and reset behaviour.
module tb_cpu_mem_responder;

  logic        clk_in;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        rdy_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        sim_halt;

  int vectors;
  int miscompares;

  cpu_mem_responder #(
    .RAM_ADDR_W(17),
    .FIFO_DEPTH(8)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .cpu_a    (cpu_a),
    .cpu_dout (cpu_dout),
    .cpu_wr   (cpu_wr),
    .cpu_din  (cpu_din),
    .rdy_out  (rdy_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .sim_halt (sim_halt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present a bus request; it is consumed at the next rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [7:0] d,
                               input logic wr);
    cpu_a    = a;
    cpu_dout = d;
    cpu_wr   = wr;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_in      = 1'b1;
    tx_ready    = 1'b0;
    applyStimulus(32'h0, 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("reset_din", cpu_din, 8'h00);
    checkOutput("reset_valid", tx_valid, 1'b0);
    checkOutput("reset_halt", sim_halt, 1'b0);
    checkOutput("reset_rdy", rdy_out, 1'b1);
    rst_in = 1'b0;
    tick();

    // RAM write then read-back, I/O hole, and high-address aliasing
    applyStimulus(32'h0000_0010, 8'hA5, 1'b1);
    tick();
    applyStimulus(32'h0000_0010, 8'h00, 1'b0);
    tick();
    checkOutput("ram_rd_a5", cpu_din, 8'hA5);
    applyStimulus(32'h0002_0010, 8'h3C, 1'b1);
    tick();
    checkOutput("din_hold_on_wr", cpu_din, 8'hA5);
    applyStimulus(32'h0002_0010, 8'h00, 1'b0);
    tick();
    checkOutput("io_hole_rd", cpu_din, 8'h00);
    applyStimulus(32'h8000_0010, 8'h00, 1'b0);
    tick();
    checkOutput("ram_alias_rd", cpu_din, 8'hA5);

    // Fill the FIFO with 0x41..0x48 while the sink is not ready
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'h0003_0000, 8'(8'h41 + i), 1'b1);
      #1;
      checkOutput($sformatf("fill_rdy%0d", i), rdy_out, 1'b1);
      tick();
    end
    checkOutput("fill_valid", tx_valid, 1'b1);
    checkOutput("fill_head", tx_data, 8'h41);
    applyStimulus(32'h0003_0004, 8'h00, 1'b0);
    tick();
    checkOutput("status_full", cpu_din, 8'h01);
    checkOutput("halt_not_on_rd", sim_halt, 1'b0);

    // Ninth write stalls while the sink stays idle
    applyStimulus(32'h0003_0000, 8'h49, 1'b1);
    #1;
    checkOutput("stall_rdy0", rdy_out, 1'b0);
    tick();
    checkOutput("stall_rdy1", rdy_out, 1'b0);
    tick();
    checkOutput("stall_rdy2", rdy_out, 1'b0);
    checkOutput("stall_din_hold", cpu_din, 8'h01);

    // One-cycle pop releases the stall on the following cycle
    tx_ready = 1'b1;
    #1;
    checkOutput("rdy_indep_txready", rdy_out, 1'b0);
    tick();
    tx_ready = 1'b0;
    checkOutput("release_rdy", rdy_out, 1'b1);
    checkOutput("release_head", tx_data, 8'h42);
    tick();
    applyStimulus(32'h0000_0010, 8'h00, 1'b0);
    #1;
    checkOutput("refull_rdy_on_rd", rdy_out, 1'b1);
    tick();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("drain%0d", i), tx_data, 8'(8'h42 + i));
      tick();
    end
    checkOutput("drained_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // Three entries, then two cycles of simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h0003_0000, 8'(8'h10 + i), 1'b1);
      tick();
    end
    tx_ready = 1'b1;
    applyStimulus(32'h0003_0000, 8'h13, 1'b1);
    tick();
    applyStimulus(32'h0003_0000, 8'h14, 1'b1);
    tick();
    applyStimulus(32'h0000_0000, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("pp_order%0d", i), tx_data, 8'(8'h12 + i));
      tick();
    end
    checkOutput("pp_count3_empty", tx_valid, 1'b0);

    // Twenty pushes streamed through with continuous popping
    for (int i = 0; i < 20; i++) begin
      applyStimulus(32'h0003_0000, 8'(8'h60 + i), 1'b1);
      if (i > 0)
        checkOutput($sformatf("wrap%0d", i), tx_data, 8'(8'h60 + i - 1));
      tick();
    end
    applyStimulus(32'h0000_0000, 8'h00, 1'b0);
    checkOutput("wrap_last", tx_data, 8'h73);
    tick();
    checkOutput("wrap_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // Sticky halt flag
    applyStimulus(32'h0003_0004, 8'h5A, 1'b1);
    tick();
    checkOutput("halt_set", sim_halt, 1'b1);
    applyStimulus(32'h0000_0000, 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("halt_sticky", sim_halt, 1'b1);

    // Five bytes queued, nonzero read data, then reset in mid-cycle
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h0003_0000, 8'(8'h70 + i), 1'b1);
      tick();
    end
    applyStimulus(32'h0000_0010, 8'h00, 1'b0);
    tick();
    checkOutput("pre_rst_din", cpu_din, 8'hA5);
    checkOutput("pre_rst_valid", tx_valid, 1'b1);
    applyStimulus(32'h0003_0000, 8'h99, 1'b1);
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("rst_valid", tx_valid, 1'b0);
    checkOutput("rst_halt", sim_halt, 1'b0);
    checkOutput("rst_din", cpu_din, 8'h00);
    checkOutput("rst_rdy", rdy_out, 1'b1);
    tick();
    applyStimulus(32'h0003_0004, 8'h00, 1'b0);
    rst_in = 1'b0;
    tick();
    checkOutput("post_rst_status", cpu_din, 8'h02);
    applyStimulus(32'h0000_0010, 8'h00, 1'b0);
    tick();
    checkOutput("ram_survives_rst", cpu_din, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
